// File: rtl/y86_pkg.sv
// Shared Y86-64 writeback definitions: instruction codes, register IDs and the
// retirement state encoding used by the writeback register file.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;

  localparam int NUM_REGS = 15;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/regfile_array.sv
// 15 x 64-bit register storage: two synchronous write ports (M wins on a
// collision) and two combinational read ports; ID 0xF reads as zero.
module regfile_array
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_e,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic        we_m,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b
);

  logic [63:0] r_regs [0:NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (4'(i) == R_RSP) ? RSP_INIT : 64'h0;
      end
    end else begin
      // M port checked first so popq %rsp keeps the loaded value.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_m && (dst_m == 4'(i))) begin
          r_regs[i] <= val_m;
        end else if (we_e && (dst_e == 4'(i))) begin
          r_regs[i] <= val_e;
        end
      end
    end
  end

  assign val_a = (src_a == R_NONE) ? 64'h0 : r_regs[src_a];
  assign val_b = (src_b == R_NONE) ? 64'h0 : r_regs[src_b];

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: derives dstE/dstM from the retiring instruction,
// writes the register file, counts retirements and tracks halt/illegal.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter int          COUNT_W  = 32,
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_valid,
  input  logic [3:0]         icode,
  input  logic               cnd,
  input  logic [3:0]         rA,
  input  logic [3:0]         rB,
  input  logic [63:0]        valE,
  input  logic [63:0]        valM,
  input  logic [3:0]         srcA,
  input  logic [3:0]         srcB,
  output logic [63:0]        valA,
  output logic [63:0]        valB,
  output logic               halted,
  output logic               illegal,
  output logic [COUNT_W-1:0] retired_count,
  output logic [1:0]         dbg_state
);

  // wb_valid is a one-cycle qualifier with no back-pressure: a retirement is
  // taken at the edge where wb_valid=1, state is RUN and reset is low;
  // otherwise the presented fields are dropped.
  wb_state_e          r_state;
  logic               r_halted;
  logic               r_illegal;
  logic [COUNT_W-1:0] r_count;
  logic [3:0]         w_dst_e;
  logic [3:0]         w_dst_m;
  logic               w_accept;
  logic               w_we_e;
  logic               w_we_m;

  always_comb begin
    w_dst_e = R_NONE;
    w_dst_m = R_NONE;
    case (icode)
      I_CMOVXX: if (cnd) w_dst_e = rB;
      I_IRMOVQ,
      I_OPQ:    w_dst_e = rB;
      I_CALL,
      I_RET,
      I_PUSHQ:  w_dst_e = R_RSP;
      I_MRMOVQ: w_dst_m = rA;
      I_POPQ: begin
        w_dst_e = R_RSP;
        w_dst_m = rA;
      end
      default: ;
    endcase
  end

  assign w_accept = wb_valid && (r_state == ST_RUN) && !reset;
  assign w_we_e   = w_accept && (w_dst_e != R_NONE);
  assign w_we_m   = w_accept && (w_dst_m != R_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else if (w_accept) begin
      r_count <= r_count + COUNT_W'(1);
      if (icode == I_HALT) begin
        r_state  <= ST_HALT;
        r_halted <= 1'b1;
      end else if (icode > I_POPQ) begin
        r_state   <= ST_ERR;
        r_illegal <= 1'b1;
      end
    end
  end

  regfile_array #(
    .RSP_INIT (RSP_INIT)
  ) u_regs (
    .clk   (clk),
    .reset (reset),
    .we_e  (w_we_e),
    .dst_e (w_dst_e),
    .val_e (valE),
    .we_m  (w_we_m),
    .dst_m (w_dst_m),
    .val_m (valM),
    .src_a (srcA),
    .src_b (srcB),
    .val_a (valA),
    .val_b (valB)
  );

  assign halted        = r_halted;
  assign illegal       = r_illegal;
  assign retired_count = r_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios plus random retirements
// compared against an array-based model of the retirement rules.
module tb_writeback_regfile;

  localparam int          CW   = 8;
  localparam logic [63:0] RSPI = 64'h100;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wb_valid = 1'b0;
  logic [3:0]    icode = 4'h1;
  logic          cnd = 1'b0;
  logic [3:0]    rA = 4'hF;
  logic [3:0]    rB = 4'hF;
  logic [63:0]   valE = 64'h0;
  logic [63:0]   valM = 64'h0;
  logic [3:0]    srcA = 4'hF;
  logic [3:0]    srcB = 4'hF;
  logic [63:0]   valA;
  logic [63:0]   valB;
  logic          halted;
  logic          illegal;
  logic [CW-1:0] retired_count;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model
  logic [63:0] m_regs [0:14];
  bit          m_halt;
  bit          m_err;
  int          m_count;

  writeback_regfile #(
    .COUNT_W  (CW),
    .RSP_INIT (RSPI)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .icode         (icode),
    .cnd           (cnd),
    .rA            (rA),
    .rB            (rB),
    .valE          (valE),
    .valM          (valM),
    .srcA          (srcA),
    .srcB          (srcB),
    .valA          (valA),
    .valB          (valB),
    .halted        (halted),
    .illegal       (illegal),
    .retired_count (retired_count),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mread(input logic [3:0] a);
    return (a == 4'hF) ? 64'h0 : m_regs[a];
  endfunction

  // Apply the retirement rules to the model for whatever is driven now.
  task automatic model_edge();
    int de;
    int dm;
    if (reset) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
      m_regs[4] = RSPI;
      m_halt = 0;
      m_err = 0;
      m_count = 0;
      return;
    end
    if (!wb_valid || m_halt || m_err) return;
    m_count = (m_count + 1) % (1 << CW);
    if (icode == 4'h0) begin
      m_halt = 1;
      return;
    end
    if (icode > 4'hB) begin
      m_err = 1;
      return;
    end
    de = 15;
    dm = 15;
    if ((icode == 4'h2 && cnd) || icode == 4'h3 || icode == 4'h6) de = rB;
    if (icode >= 4'h8 && icode <= 4'hB) de = 4;
    if (icode == 4'h5 || icode == 4'hB) dm = rA;
    if (de != 15 && de != dm) m_regs[de] = valE;
    if (dm != 15) m_regs[dm] = valM;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic c, input logic [3:0] a,
                       input logic [3:0] b, input logic [63:0] e, input logic [63:0] m);
    wb_valid = 1'b1;
    icode = ic;
    cnd = c;
    rA = a;
    rB = b;
    valE = e;
    valM = m;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wb_valid = 1'b0;
    step();
    reset = 1'b0;
    srcA = 4'h4;
    srcB = 4'h0;
    #1;
    n_checks++;
    if (valA !== 64'h100) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h want %h", valA, 64'h100);
    end
    n_checks++;
    if (valB !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_r0: got %h want 0", valB);
    end
    n_checks++;
    if (retired_count !== 8'd0 || halted !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: count=%0d halted=%b illegal=%b want 0/0/0",
               retired_count, halted, illegal);
    end
  endtask

  task automatic test_irmovq();
    drive(4'h3, 1'b0, 4'hF, 4'h2, 64'hABCD, 64'h0);
    srcB = 4'h2;
    #1;
    n_checks++;
    if (valB !== 64'h0) begin
      n_fail++;
      $display("FAIL irmovq_no_bypass: got %h want 0", valB);
    end
    step();
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (valB !== 64'hABCD) begin
      n_fail++;
      $display("FAIL irmovq_write: got %h want %h", valB, 64'hABCD);
    end
    n_checks++;
    if (retired_count !== 8'd1) begin
      n_fail++;
      $display("FAIL irmovq_count: got %0d want 1", retired_count);
    end
  endtask

  task automatic test_cmov();
    srcA = 4'h5;
    drive(4'h2, 1'b0, 4'hF, 4'h5, 64'h7, 64'h0);
    step();
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (valA !== 64'h0) begin
      n_fail++;
      $display("FAIL cmov_cnd0: got %h want 0", valA);
    end
    drive(4'h2, 1'b1, 4'hF, 4'h5, 64'h7, 64'h0);
    step();
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (valA !== 64'h7) begin
      n_fail++;
      $display("FAIL cmov_cnd1: got %h want 7", valA);
    end
  endtask

  task automatic test_popq();
    srcA = 4'h4;
    drive(4'hB, 1'b0, 4'h4, 4'hF, 64'h108, 64'h55);
    step();
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (valA !== 64'h55) begin
      n_fail++;
      $display("FAIL popq_rsp: got %h want 55", valA);
    end
    n_checks++;
    if (retired_count !== 8'(m_count)) begin
      n_fail++;
      $display("FAIL popq_count: got %0d want %0d", retired_count, m_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      wb_valid = ($urandom_range(0, 3) != 0);
      icode = 4'($urandom_range(1, 11));
      cnd = 1'($urandom_range(0, 1));
      rA = 4'($urandom_range(0, 15));
      rB = 4'($urandom_range(0, 15));
      valE = {$urandom, $urandom};
      valM = {$urandom, $urandom};
      srcA = 4'($urandom_range(0, 15));
      srcB = 4'($urandom_range(0, 15));
      #1;
      n_checks++;
      if (valA !== mread(srcA) || valB !== mread(srcB)) begin
        n_fail++;
        $display("FAIL rand_read: src=%h/%h got %h/%h want %h/%h",
                 srcA, srcB, valA, valB, mread(srcA), mread(srcB));
      end
      step();
      n_checks++;
      if (retired_count !== 8'(m_count)) begin
        n_fail++;
        $display("FAIL rand_count: got %0d want %0d", retired_count, m_count);
      end
    end
    wb_valid = 1'b0;
    for (int r = 0; r < 15; r++) begin
      srcA = 4'(r);
      srcB = 4'(14 - r);
      #1;
      n_checks++;
      if (valA !== mread(srcA) || valB !== mread(srcB)) begin
        n_fail++;
        $display("FAIL rand_sweep: r=%0d got %h/%h want %h/%h",
                 r, valA, valB, mread(srcA), mread(srcB));
      end
    end
  endtask

  task automatic test_halt();
    logic [63:0] r1_before;
    int          cnt_before;
    srcA = 4'h1;
    drive(4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
    #1;
    n_checks++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_early: got %b want 0", halted);
    end
    step();
    n_checks++;
    if (halted !== 1'b1 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_flag: halted=%b illegal=%b want 1/0", halted, illegal);
    end
    r1_before = mread(4'h1);
    cnt_before = m_count;
    drive(4'h3, 1'b0, 4'hF, 4'h1, 64'hDEAD_BEEF, 64'h0);
    step();
    step();
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (valA !== r1_before || retired_count !== 8'(cnt_before) || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_frozen: r1=%h count=%0d halted=%b want %h/%0d/1",
               valA, retired_count, halted, r1_before, cnt_before);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    srcA = 4'h4;
    #1;
    n_checks++;
    if (halted !== 1'b0 || retired_count !== 8'd0 || valA !== RSPI) begin
      n_fail++;
      $display("FAIL halt_reset: halted=%b count=%0d rsp=%h want 0/0/%h",
               halted, retired_count, valA, RSPI);
    end
  endtask

  task automatic test_illegal();
    srcB = 4'h3;
    drive(4'($urandom_range(12, 15)), 1'b1, 4'h3, 4'h3, 64'h1234, 64'h5678);
    step();
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (illegal !== 1'b1 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_flag: illegal=%b halted=%b want 1/0", illegal, halted);
    end
    n_checks++;
    if (valB !== mread(4'h3) || retired_count !== 8'(m_count)) begin
      n_fail++;
      $display("FAIL illegal_nowrite: r3=%h count=%0d want %h/%0d",
               valB, retired_count, mread(4'h3), m_count);
    end
    drive(4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
    step();
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (illegal !== 1'b1 || halted !== 1'b0 || retired_count !== 8'(m_count)) begin
      n_fail++;
      $display("FAIL illegal_sticky: illegal=%b halted=%b count=%0d want 1/0/%0d",
               illegal, halted, retired_count, m_count);
    end
  endtask

  task automatic test_reset_priority();
    srcA = 4'h6;
    reset = 1'b1;
    drive(4'h3, 1'b0, 4'hF, 4'h6, 64'h77, 64'h0);
    step();
    reset = 1'b0;
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (valA !== 64'h0 || retired_count !== 8'd0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority: r6=%h count=%0d illegal=%b want 0/0/0",
               valA, retired_count, illegal);
    end
  endtask

  initial begin
    for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
    m_halt = 0;
    m_err = 0;
    m_count = 0;
    test_reset();
    test_irmovq();
    test_cmov();
    test_popq();
    test_random();
    test_halt();
    test_illegal();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
